rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Round-robin arbiter that shares the single write port (we/a2/wd) of the register file between four requesters. Each requester presents a write through a valid/ready handshake. The arbiter registers the winning write and drives it onto the register-file write port one cycle later. A requester may lock the port for a bounded burst of back-to-back writes.

## Interface
- WIDTH, 4: data width; matches the register file WIDTH.
- ADDRESS_WIDTH, 2: register address width; matches the register file ADDRESS_WIDTH.
- BURST_MAX, 4: maximum consecutive beats granted to one locked requester; legal range 2..15.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  4  bit i: requester i offers a write.
- req_lock  in  4  bit i: requester i asks to keep the grant after this beat; sampled only on an accepted beat.
- req_addr  in  4*ADDRESS_WIDTH  slice i = requester i target register.
- req_data  in  4*WIDTH  slice i = requester i write data.
- req_ready  out  4  one-hot or zero, combinational; a beat is accepted when req_valid[i] & req_ready[i].
- we  out  1  register-file write enable, registered.
- a2  out  ADDRESS_WIDTH  register-file write address, registered.
- wd  out  WIDTH  register-file write data, registered.
- grant_id  out  2  index of the requester whose beat is on we/a2/wd, registered.

## Operation
- State: FSM {IDLE, LOCKED}, rr_ptr[1:0], owner[1:0], burst_cnt[3:0].
- IDLE: grant the first requester with req_valid set, searching from rr_ptr upward with wrap 3→0. req_ready is one-hot on the winner and zero if no requester is valid.
- On an accepted beat in IDLE from requester k:
  - rr_ptr ← k+1 mod 4.
  - If req_lock[k]=1: go to LOCKED, owner ← k, burst_cnt ← 1.
- LOCKED: only the owner can be granted; req_ready[owner]=req_valid[owner] and all other bits are 0.
  - Accepted beat with req_lock=0: go to IDLE.
  - Accepted beat with burst_cnt+1 = BURST_MAX: go to IDLE regardless of req_lock. This is forced release.
  - Otherwise: burst_cnt increments.
  - Owner req_valid=0 in LOCKED: no grant that cycle (bubble), then go to IDLE.
- rr_ptr stays at owner+1 throughout the lock, so the next requester after the owner has priority on release.
- Output stage:
  - On an accepted beat: we←1, a2←req_addr[k], wd←req_data[k], grant_id←k.
  - With no accepted beat: we←0, and a2/wd/grant_id hold their values.
- Requesters must hold addr/data/lock stable while valid is high and ready is low. The arbiter does not check this.

## Timing
- Request to write-port latency: beat accepted at edge N, so we/a2/wd are valid during cycle N+1 and the register file captures the write at edge N+2.
- Throughput is one write per cycle; there are no bubbles between different requesters.
- The only bubble is the owner-valid-low case in LOCKED.
- Reset values:
  - we=0, a2=0, wd=0, grant_id=0.
  - rr_ptr=0, owner=0, burst_cnt=0, state IDLE.
  - req_ready=0 during any cycle in which reset is high.
- Reset asserted mid-burst abandons the lock. An in-flight registered write is cleared (we=0 after the reset edge) and is not retried.
- Simultaneous valids are resolved purely by rr_ptr order; there is no fixed priority.

## Configuration
- RF_ARB_DROP_ZERO_EN defined:
  - An accepted beat with address 0 is handshaken normally and updates rr_ptr, lock and burst state.
  - That beat does not assert we; we stays 0 for that cycle, while a2/wd/grant_id update. Register 0 reads as constant zero, so this write is pointless.
- RF_ARB_DROP_ZERO_EN undefined: address-0 beats are issued like any other (we=1, a2=0).

## Test plan
- After reset, req_valid=4'b1111, no lock, addr_i=i, data_i=i+8 → accepts in order 0,1,2,3,0. we=1 from cycle 2 onward; (a2,wd) sequence is (0,8),(1,9),(2,A),(3,B).
- Only req 2 valid, addr 3, data 0xA → req_ready=4'b0100 in the same cycle; next cycle we=1, a2=3, wd=0xA, grant_id=2.
- BURST_MAX=4; req1 valid+lock for 6 beats, req0 valid throughout → grants are 1,1,1,1 (forced release), then 0 (rr_ptr=2 wraps to 0), then 1,1.
- Owner 3 locked, drops valid for one cycle, req0 valid → req_ready=0 in the bubble cycle, then req0 granted; we=0 in the cycle after the bubble.
- Address-0 write, data 0x5 → with RF_ARB_DROP_ZERO_EN: handshake completes and we stays 0. Without the macro: we=1, a2=0, wd=0x5.
- Reset asserted in the cycle after the second locked beat → next cycle we=0, a2=0, wd=0, grant_id=0, req_ready=0. After release, requester 0 wins first among all valid.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port (we/a2/wd) among four requesters.
// Optional RF_ARB_DROP_ZERO_EN: accepted beats addressed to register 0 do not assert we.
module rf_write_arbiter #(
  parameter int WIDTH         = 4,
  parameter int ADDRESS_WIDTH = 2,
  parameter int BURST_MAX     = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [3:0]                 req_valid,
  input  logic [3:0]                 req_lock,
  input  logic [4*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [4*WIDTH-1:0]         req_data,
  output logic [3:0]                 req_ready,
  output logic                       we,
  output logic [ADDRESS_WIDTH-1:0]   a2,
  output logic [WIDTH-1:0]           wd,
  output logic [1:0]                 grant_id,
  output logic                       state_dbg
);

  // Handshake: requester i's beat is accepted in a cycle where req_valid[i] & req_ready[i];
  // addr/data/lock must stay stable while valid is high and ready is low.

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                     state, state_n;
  logic [1:0]                 rr_ptr, rr_ptr_n;
  logic [1:0]                 owner, owner_n;
  logic [3:0]                 burst_cnt, burst_cnt_n;
  logic                       accept;
  logic [1:0]                 grant_idx;
  logic [1:0]                 cand;
  logic [ADDRESS_WIDTH-1:0]   sel_addr;
  logic [WIDTH-1:0]           sel_data;
  logic                       beat_we;

  assign state_dbg = state;

  // Winner selection: rotating search from rr_ptr in IDLE, owner only in LOCKED.
  always_comb begin
    req_ready = 4'b0000;
    grant_idx = 2'd0;
    accept    = 1'b0;
    cand      = 2'd0;
    if (!reset) begin
      if (state == IDLE) begin
        for (int off = 0; off < 4; off++) begin
          cand = rr_ptr + 2'(off);
          if (!accept && req_valid[cand]) begin
            accept    = 1'b1;
            grant_idx = cand;
          end
        end
      end else begin
        accept    = req_valid[owner];
        grant_idx = owner;
      end
      if (accept) req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_addr = req_addr[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    sel_data = req_data[int'(grant_idx)*WIDTH +: WIDTH];
  end

`ifdef RF_ARB_DROP_ZERO_EN
  assign beat_we = accept && (sel_addr != '0);
`else
  assign beat_we = accept;
`endif

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    owner_n     = owner;
    burst_cnt_n = burst_cnt;
    if (state == IDLE) begin
      if (accept) begin
        rr_ptr_n = grant_idx + 2'd1;
        if (req_lock[grant_idx]) begin
          state_n     = LOCKED;
          owner_n     = grant_idx;
          burst_cnt_n = 4'd1;
        end
      end
    end else begin
      // rr_ptr already points past the owner, so it is left alone during the lock.
      if (!accept) begin
        state_n     = IDLE;
        burst_cnt_n = 4'd0;
      end else if (!req_lock[owner] || (burst_cnt + 4'd1 == 4'(BURST_MAX))) begin
        state_n     = IDLE;
        burst_cnt_n = 4'd0;
      end else begin
        burst_cnt_n = burst_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      owner     <= 2'd0;
      burst_cnt <= 4'd0;
      we        <= 1'b0;
      a2        <= '0;
      wd        <= '0;
      grant_id  <= 2'd0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      owner     <= owner_n;
      burst_cnt <= burst_cnt_n;
      we        <= beat_we;
      if (accept) begin
        a2       <= sel_addr;
        wd       <= sel_data;
        grant_id <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (default parameters).
module tb_rf_write_arbiter;

  localparam int W  = 4;
  localparam int AW = 2;

  logic          clock;
  logic          reset;
  logic [3:0]    req_valid;
  logic [3:0]    req_lock;
  logic [4*AW-1:0] req_addr;
  logic [4*W-1:0]  req_data;
  logic [3:0]    req_ready;
  logic          we;
  logic [AW-1:0] a2;
  logic [W-1:0]  wd;
  logic [1:0]    grant_id;
  logic          state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];

  rf_write_arbiter #(.WIDTH(W), .ADDRESS_WIDTH(AW), .BURST_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .we(we), .a2(a2), .wd(wd), .grant_id(grant_id),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs;
    req_valid = 4'b0;
    req_lock  = 4'b0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid[i]         = v;
    req_lock[i]          = l;
    req_addr[i*AW +: AW] = a;
    req_data[i*W +: W]   = d;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_reqs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic exp_we_for(input logic [AW-1:0] a);
`ifdef RF_ARB_DROP_ZERO_EN
    return (a != '0);
`else
    return 1'b1;
`endif
  endfunction

  // Scenarios
  task automatic test_reset;
    reset = 1'b1;
    clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 2'(i), 4'(i + 1));
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    tick();
    n_checks++;
    if ({we, a2, wd, grant_id, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b a2=%0h wd=%0h gid=%0d st=%b want all 0", we, a2, wd, grant_id, state_dbg);
    end
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_hold: got %b want 0000", req_ready); end
    tick();
    reset = 1'b0;
    clear_reqs();
  endtask

  task automatic test_round_robin;
    logic [1:0] k;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 2'(i), 4'(i + 8));
    for (int n = 0; n < 5; n++) begin
      k = 2'(n % 4);
      #1;
      n_checks++;
      if (req_ready !== (4'b0001 << k)) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", n, req_ready, 4'b0001 << k);
      end
      tick();
      n_checks++;
      if (we !== exp_we_for(k) || a2 !== k || wd !== 4'(k + 8) || grant_id !== k) begin
        n_fail++;
        $display("FAIL rr_port[%0d]: we=%b a2=%0h wd=%0h gid=%0d want we=%b a2=%0h wd=%0h gid=%0d",
                 n, we, a2, wd, grant_id, exp_we_for(k), k, 4'(k + 8), k);
      end
    end
    clear_reqs();
  endtask

  task automatic test_single;
    do_reset();
    set_req(2, 1'b1, 1'b0, 2'd3, 4'hA);
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    n_checks++;
    if (we !== 1'b1 || a2 !== 2'd3 || wd !== 4'hA || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL single_port: we=%b a2=%0h wd=%0h gid=%0d want 1 3 a 2", we, a2, wd, grant_id);
    end
    clear_reqs();
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready: got %b want 0000", req_ready); end
    tick();
    n_checks++;
    if (we !== 1'b0 || a2 !== 2'd3 || wd !== 4'hA || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL idle_hold: we=%b a2=%0h wd=%0h gid=%0d want 0 3 a 2", we, a2, wd, grant_id);
    end
  endtask

  task automatic test_burst;
    logic [1:0] k;
    logic exp_st [0:6];
    exp_st = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    set_req(0, 1'b1, 1'b0, 2'd1, 4'h1);
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL burst_pre_ready: got %b want 0001", req_ready); end
    tick();
    set_req(1, 1'b1, 1'b1, 2'd2, 4'h6);
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
    for (int n = 0; n < 7; n++) begin
      k = exp_q.pop_front();
      #1;
      n_checks++;
      if (req_ready !== (4'b0001 << k)) begin
        n_fail++; $display("FAIL burst_ready[%0d]: got %b want %b", n, req_ready, 4'b0001 << k);
      end
      tick();
      n_checks++;
      if (we !== 1'b1 || grant_id !== k || wd !== ((k == 2'd1) ? 4'h6 : 4'h1) || state_dbg !== exp_st[n]) begin
        n_fail++;
        $display("FAIL burst_port[%0d]: we=%b gid=%0d wd=%0h st=%b want we=1 gid=%0d st=%b",
                 n, we, grant_id, wd, state_dbg, k, exp_st[n]);
      end
    end
    clear_reqs();
  endtask

  task automatic test_bubble;
    do_reset();
    set_req(3, 1'b1, 1'b1, 2'd2, 4'hC);
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bubble_lock_ready: got %b want 1000", req_ready); end
    tick();
    n_checks++;
    if (we !== 1'b1 || grant_id !== 2'd3 || state_dbg !== 1'b1) begin
      n_fail++; $display("FAIL bubble_lock_port: we=%b gid=%0d st=%b want 1 3 1", we, grant_id, state_dbg);
    end
    set_req(3, 1'b0, 1'b1, 2'd2, 4'hC);
    set_req(0, 1'b1, 1'b0, 2'd1, 4'h7);
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bubble_ready: got %b want 0000", req_ready); end
    tick();
    n_checks++;
    if (we !== 1'b0 || grant_id !== 2'd3 || state_dbg !== 1'b0) begin
      n_fail++; $display("FAIL bubble_port: we=%b gid=%0d st=%b want 0 3 0", we, grant_id, state_dbg);
    end
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL post_bubble_ready: got %b want 0001", req_ready); end
    tick();
    n_checks++;
    if (we !== 1'b1 || grant_id !== 2'd0 || a2 !== 2'd1 || wd !== 4'h7) begin
      n_fail++; $display("FAIL post_bubble_port: we=%b gid=%0d a2=%0h wd=%0h want 1 0 1 7", we, grant_id, a2, wd);
    end
    clear_reqs();
  endtask

  task automatic test_drop_zero;
    do_reset();
    set_req(1, 1'b1, 1'b0, 2'd0, 4'h5);
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL zero_ready: got %b want 0010", req_ready); end
    tick();
    n_checks++;
    if (we !== exp_we_for(2'd0) || a2 !== 2'd0 || wd !== 4'h5 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL zero_port: we=%b a2=%0h wd=%0h gid=%0d want we=%b a2=0 wd=5 gid=1",
               we, a2, wd, grant_id, exp_we_for(2'd0));
    end
    set_req(2, 1'b1, 1'b0, 2'd2, 4'h3);
    set_req(1, 1'b1, 1'b0, 2'd1, 4'h4);
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL zero_rr_ready: got %b want 0100", req_ready); end
    tick();
    clear_reqs();
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    set_req(2, 1'b1, 1'b1, 2'd3, 4'h9);
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_ready1: got %b want 0100", req_ready); end
    tick();
    #1;
    n_checks++;
    if (req_ready !== 4'b0100 || state_dbg !== 1'b1) begin
      n_fail++; $display("FAIL mid_ready2: got %b st=%b want 0100 st=1", req_ready, state_dbg);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 2'(i + 1), 4'(i + 2));
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 0000", req_ready); end
    tick();
    n_checks++;
    if (we !== 1'b0 || a2 !== 2'd0 || wd !== 4'h0 || grant_id !== 2'd0 || state_dbg !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_port: we=%b a2=%0h wd=%0h gid=%0d st=%b want all 0", we, a2, wd, grant_id, state_dbg);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL after_reset_ready: got %b want 0001", req_ready); end
    tick();
    n_checks++;
    if (we !== 1'b1 || grant_id !== 2'd0 || a2 !== 2'd1 || wd !== 4'h2) begin
      n_fail++; $display("FAIL after_reset_port: we=%b gid=%0d a2=%0h wd=%0h want 1 0 1 2", we, grant_id, a2, wd);
    end
    clear_reqs();
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    test_reset();
    test_round_robin();
    test_single();
    test_burst();
    test_bubble();
    test_drop_zero();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
